// File: rtl/fir_mac_unit.sv
// One tap-group MAC unit of the FIR filter: a TAPS-deep sample delay line and coefficient
// bank, serially multiply-accumulated after every sample strobe into a full-precision result.
`timescale 1ns/1ps
module fir_mac_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 6,
  parameter int TAPS       = 8,
  parameter int ACC_WIDTH  = 25
) (
  input  logic                         iClk12M,
  input  logic                         iRst,
  input  logic                         iEnSample600k,
  input  logic signed [DATA_WIDTH-1:0] iFirIn,
  input  logic                         iCoefWr,
  input  logic [3:0]                   iCoefAddr,
  input  logic signed [COEF_WIDTH-1:0] iCoefData,
  output logic signed [DATA_WIDTH-1:0] oDelayTail,
  output logic signed [ACC_WIDTH-1:0]  oMac,
  output logic                         oMacValid,
  output logic                         oBusy,
  output logic                         oOverrun
);
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
  localparam int IDX_WIDTH  = $clog2(TAPS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(TAPS - 1);
  localparam logic [4:0] TAPS_LIM = 5'(TAPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic signed [DATA_WIDTH-1:0] r_dly  [TAPS];
  logic signed [COEF_WIDTH-1:0] r_coef [TAPS];
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [ACC_WIDTH-1:0]  r_mac;
  logic [IDX_WIDTH-1:0]         r_idx;
  logic                         r_valid;
  logic                         r_busy;
  logic                         r_overrun;
  logic                         w_accept;
  logic                         w_coef_we;
  logic signed [PROD_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;

  // Full-width signed product of the current tap, sign-extended to the accumulator width.
  assign w_prod     = PROD_WIDTH'(r_dly[r_idx]) * PROD_WIDTH'(r_coef[r_idx]);
  assign w_prod_ext = ACC_WIDTH'(w_prod);

  assign oDelayTail = r_dly[TAPS-1];
  assign oMac       = r_mac;
  assign oMacValid  = r_valid;
  assign oBusy      = r_busy;
  assign oOverrun   = r_overrun;

  // Next-state decode plus strobe acceptance and coefficient write gating.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_coef_we   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_coef_we = iCoefWr && ({1'b0, iCoefAddr} < TAPS_LIM);
        if (iEnSample600k) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MAC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MAC: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_MAC;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, delay line, coefficient bank, accumulator and registered outputs.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mac     <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_dly[i]  <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_valid <= (r_state == S_DONE);
      if (w_accept) begin
        r_dly[0] <= iFirIn;
        for (int i = 1; i < TAPS; i++) begin
          r_dly[i] <= r_dly[i-1];
        end
        r_acc <= '0;
        r_idx <= '0;
      end else if (r_state == S_MAC) begin
        r_acc <= r_acc + w_prod_ext;
        r_idx <= r_idx + 1'b1;
      end
      if (w_coef_we) begin
        r_coef[iCoefAddr[IDX_WIDTH-1:0]] <= iCoefData;
      end
      if (r_state == S_DONE) begin
        r_mac <= r_acc;
      end
      // A strobe while busy is dropped but remembered until reset.
      if (iEnSample600k && r_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fir_mac_unit.sv
// Self-checking bench for fir_mac_unit: table-driven strobes with a result scoreboard,
// plus hand-written overrun, coefficient-gating, reset and chaining sequences.
`timescale 1ns/1ps
module tb_fir_mac_unit;
  logic               clk = 1'b0;
  logic               iRst = 1'b0;
  logic               iEnSample600k = 1'b0;
  logic signed [15:0] iFirIn = '0;
  logic               iCoefWr = 1'b0;
  logic [3:0]         iCoefAddr = '0;
  logic signed [5:0]  iCoefData = '0;
  logic signed [15:0] oDelayTail;
  logic signed [24:0] oMac;
  logic               oMacValid;
  logic               oBusy;
  logic               oOverrun;
  logic signed [15:0] u1_tail;
  logic signed [24:0] u1_mac;
  logic               u1_valid;
  logic               u1_busy;
  logic               u1_ovr;

  typedef struct {
    logic signed [15:0] sample;
    logic signed [24:0] exp_mac;
  } vec_t;

  typedef struct {
    logic signed [24:0] mac;
    int                 due;
  } sb_t;

  vec_t vt[24];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  fir_mac_unit dut (
    .iClk12M(clk), .iRst(iRst), .iEnSample600k(iEnSample600k), .iFirIn(iFirIn),
    .iCoefWr(iCoefWr), .iCoefAddr(iCoefAddr), .iCoefData(iCoefData),
    .oDelayTail(oDelayTail), .oMac(oMac), .oMacValid(oMacValid),
    .oBusy(oBusy), .oOverrun(oOverrun)
  );

  fir_mac_unit u1 (
    .iClk12M(clk), .iRst(iRst), .iEnSample600k(iEnSample600k), .iFirIn(oDelayTail),
    .iCoefWr(iCoefWr), .iCoefAddr(iCoefAddr), .iCoefData(iCoefData),
    .oDelayTail(u1_tail), .oMac(u1_mac), .oMacValid(u1_valid),
    .oBusy(u1_busy), .oOverrun(u1_ovr)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expected result and its due cycle.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (oMacValid) begin
      chk("valid_single_cycle", 32'(prev_valid), 32'sd0);
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'sd1, 32'sd0);
      end else begin
        chk("mac_value", oMac, sb[0].mac);
        chk("mac_latency", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
    prev_valid = oMacValid;
  end

  task automatic do_reset();
    @(negedge clk);
    iRst = 1'b1;
    repeat (2) @(negedge clk);
    iRst = 1'b0;
    sb.delete();
  endtask

  task automatic coef_write(input logic [3:0] a, input logic signed [5:0] d);
    @(negedge clk);
    iCoefWr = 1'b1;
    iCoefAddr = a;
    iCoefData = d;
    @(negedge clk);
    iCoefWr = 1'b0;
  endtask

  // One sample period: strobe, optional coefficient write at cycle wr_off, expected result pushed.
  task automatic strobe(input logic signed [15:0] s, input logic signed [24:0] exp_mac,
                        input bit wr_en, input int wr_off, input logic [3:0] wa,
                        input logic signed [5:0] wd);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      iEnSample600k = (c == 0);
      iFirIn = s;
      iCoefWr = wr_en && (c == wr_off);
      iCoefAddr = wa;
      iCoefData = wd;
      if (c == 0) sb.push_back('{mac: exp_mac, due: cyc + 10});
      if (c == 5) chk("busy_in_mac", 32'(oBusy), 32'sd1);
    end
    iCoefWr = 1'b0;
  endtask

  initial begin
    // Impulse through coefs 1..8, then full-scale extremes with coefs all -32.
    vt[0] = '{16'sd100, 25'sd100};
    for (int k = 1; k < 8; k++) vt[k] = '{16'sd0, 25'(100 * (k + 1))};
    for (int k = 0; k < 8; k++) vt[8 + k] = '{16'sh8000, 25'(1048576 * (k + 1))};
    vt[16] = '{16'sh7FFF, 25'sd6291488};
    vt[17] = '{16'sh7FFF, 25'sd4194368};
    vt[18] = '{16'sh7FFF, 25'sd2097248};
    vt[19] = '{16'sh7FFF, 25'sd128};
    vt[20] = '{16'sh7FFF, -25'sd2096992};
    vt[21] = '{16'sh7FFF, -25'sd4194112};
    vt[22] = '{16'sh7FFF, -25'sd6291232};
    vt[23] = '{16'sh7FFF, -25'sd8388352};

    do_reset();
    chk("rst_mac", oMac, 32'sd0);
    chk("rst_valid", 32'(oMacValid), 32'sd0);
    chk("rst_busy", 32'(oBusy), 32'sd0);
    chk("rst_overrun", 32'(oOverrun), 32'sd0);
    chk("rst_tail", oDelayTail, 32'sd0);

    for (int k = 0; k < 8; k++) coef_write(4'(k), 6'(k + 1));
    for (int v = 0; v < 8; v++) strobe(vt[v].sample, vt[v].exp_mac, 1'b0, 0, 4'd0, 6'sd0);
    chk("impulse_tail", oDelayTail, 32'sd100);
    chk("impulse_hold", oMac, 32'sd800);

    for (int k = 0; k < 8; k++) coef_write(4'(k), 6'sh20);
    for (int v = 8; v < 24; v++) strobe(vt[v].sample, vt[v].exp_mac, 1'b0, 0, 4'd0, 6'sd0);
    chk("extreme_tail", oDelayTail, 32'sd32767);

    // Reset in the middle of a MAC sequence: no pulse, everything cleared.
    @(negedge clk);
    iEnSample600k = 1'b1;
    iFirIn = 16'sd1234;
    @(negedge clk);
    iEnSample600k = 1'b0;
    repeat (2) @(negedge clk);
    iRst = 1'b1;
    @(negedge clk);
    iRst = 1'b0;
    chk("midrst_mac", oMac, 32'sd0);
    chk("midrst_tail", oDelayTail, 32'sd0);
    chk("midrst_busy", 32'(oBusy), 32'sd0);
    chk("midrst_valid", 32'(oMacValid), 32'sd0);
    repeat (12) @(negedge clk);

    // Overrun: second strobe during MAC is dropped and flagged.
    do_reset();
    coef_write(4'd0, 6'sd3);
    @(negedge clk);
    iEnSample600k = 1'b1;
    iFirIn = 16'sd1000;
    sb.push_back('{mac: 25'sd3000, due: cyc + 10});
    @(negedge clk);
    iEnSample600k = 1'b0;
    repeat (4) @(negedge clk);
    iEnSample600k = 1'b1;
    iFirIn = 16'sd2000;
    @(negedge clk);
    iEnSample600k = 1'b0;
    repeat (10) @(negedge clk);
    chk("overrun_set", 32'(oOverrun), 32'sd1);
    coef_write(4'd1, 6'sd1);
    strobe(16'sd0, 25'sd1000, 1'b0, 0, 4'd0, 6'sd0);
    chk("overrun_sticky", 32'(oOverrun), 32'sd1);

    // Coefficient gating: out-of-range address, same-cycle write, write while busy.
    do_reset();
    coef_write(4'd3, 6'sd2);
    coef_write(4'd9, 6'sd5);
    strobe(16'sd10, 25'sd50, 1'b1, 0, 4'd0, 6'sd5);
    strobe(16'sd0, 25'sd0, 1'b0, 0, 4'd0, 6'sd0);
    strobe(16'sd0, 25'sd0, 1'b1, 4, 4'd3, 6'sd7);
    strobe(16'sd0, 25'sd20, 1'b0, 0, 4'd0, 6'sd0);
    chk("gating_no_overrun", 32'(oOverrun), 32'sd0);

    // Chaining: second unit fed from the first unit's delay-line tail.
    do_reset();
    for (int k = 1; k <= 16; k++) strobe(16'(k), 25'sd0, 1'b0, 0, 4'd0, 6'sd0);
    chk("chain_u0_tail", oDelayTail, 32'sd9);
    chk("chain_u1_tail", u1_tail, 32'sd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'sd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
